// File: rtl/bus_arb_pkg.sv
// Shared types, default parameters and the round-robin pick function
// used by the tristate bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    localparam int N_DEF          = 4;
    localparam int TURNAROUND_DEF = 1;
    localparam int MAX_HOLD_DEF   = 8;
    localparam int N_MAX          = 8;

    // First set bit of req searching upward from last+1, wrapping modulo n.
    function automatic logic [N_MAX-1:0] rr_pick(input logic [N_MAX-1:0] req,
                                                 input logic [2:0]       last,
                                                 input int               n);
        logic [N_MAX-1:0] g;
        int               idx;
        g = '0;
        for (int k = 1; k <= N_MAX; k++) begin
            idx = (int'(last) + k) % n;
            if (k <= n && g == '0 && req[idx[2:0]])
                g[idx[2:0]] = 1'b1;
        end
        return g;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin selector: one-hot grant, its index, and
// whether any request is present.
module rr_priority_pick
    import bus_arb_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_last,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_any
);
    localparam int IW = $clog2(N);

    logic [N_MAX-1:0] w_req_ext;
    logic [N_MAX-1:0] w_grant_ext;

    genvar gi;
    generate
        for (gi = 0; gi < N_MAX; gi++) begin : g_ext
            if (gi < N) begin : g_used
                assign w_req_ext[gi] = i_req[gi];
            end else begin : g_pad
                assign w_req_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_grant_ext = rr_pick(w_req_ext, 3'(i_last), N);
    assign o_grant     = w_grant_ext[N-1:0];
    assign o_any       = |i_req;

    always_comb begin
        o_idx = '0;
        for (int k = 0; k < N; k++)
            if (o_grant[k]) o_idx = IW'(k);
    end

endmodule

// File: rtl/tristate_buffer.sv
// Single tristate bus driver: drives a onto y while c is high, else floats.
module tristate_buffer #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic         c,
    output tri   [W-1:0] y
);
    assign y = c ? a : {W{1'bz}};
endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter producing registered one-hot tristate enables, with
// mandatory all-off turnaround between owners and a per-owner hold limit.
module tristate_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int TURNAROUND = TURNAROUND_DEF,
    parameter int MAX_HOLD   = MAX_HOLD_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         oe,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic                 turn
);
    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURNAROUND + 1);

    state_t         r_state;
    logic [N-1:0]   r_oe;
    logic [IW-1:0]  r_owner;
    logic [IW-1:0]  r_last;
    logic [HW-1:0]  r_hold;
    logic [TW-1:0]  r_tcnt;
    logic           r_busy;
    logic           r_turn;

    logic [N-1:0]   w_grant;
    logic [IW-1:0]  w_idx;
    logic           w_any;
    logic           w_others;
    logic           w_at_limit;

    rr_priority_pick #(.N(N)) u_pick (
        .i_req   (req),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // r_oe is the owner's one-hot while granted, so masking it leaves the rivals.
    assign w_others   = |(req & ~r_oe);
    assign w_at_limit = (r_hold == HW'(MAX_HOLD));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_oe    <= '0;
            r_owner <= '0;
            r_last  <= IW'(N - 1);
            r_hold  <= '0;
            r_tcnt  <= '0;
            r_busy  <= 1'b0;
            r_turn  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_GRANT;
                        r_oe    <= w_grant;
                        r_owner <= w_idx;
                        r_last  <= w_idx;
                        r_hold  <= HW'(1);
                        r_busy  <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (!req[r_owner] || (w_at_limit && w_others)) begin
                        r_state <= ST_TURN;
                        r_oe    <= '0;
                        r_busy  <= 1'b0;
                        r_turn  <= 1'b1;
                        r_tcnt  <= TW'(TURNAROUND);
                    end else if (!w_at_limit) begin
                        r_hold  <= r_hold + 1'b1;
                    end
                end
                ST_TURN: begin
                    // Only the request vector at the expiry edge is arbitrated.
                    if (r_tcnt == TW'(1)) begin
                        r_turn <= 1'b0;
                        if (w_any) begin
                            r_state <= ST_GRANT;
                            r_oe    <= w_grant;
                            r_owner <= w_idx;
                            r_last  <= w_idx;
                            r_hold  <= HW'(1);
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_tcnt <= r_tcnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_oe    <= '0;
                    r_busy  <= 1'b0;
                    r_turn  <= 1'b0;
                end
            endcase
        end
    end

    assign oe    = r_oe;
    assign owner = r_owner;
    assign busy  = r_busy;
    assign turn  = r_turn;

endmodule

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
- Controller directly upstream of the tristate buffers that share one bus.
- Arbitrates among N requesters and drives one registered, one-hot output-enable per requester; each enable feeds a buffer's `c` input.
- Inserts turnaround cycles between owners, so no two buffers ever drive the bus in the same cycle and the bus floats (z) between owners.
- Round-robin priority, plus a hold limit so no requester can monopolise the bus.

Parameters:
- N, 4, number of requesters / tristate buffers on the bus (2..8).
- TURNAROUND, 1, cycles with all enables low between two different ownership periods (1..4; 0 not allowed).
- MAX_HOLD, 8, maximum consecutive GRANT cycles while another requester is pending (≥1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  per-requester bus request; level, held while the bus is wanted.
- oe  output  N  one-hot-or-zero enable to the tristate buffers (`c` inputs); registered.
- owner  output  $clog2(N)  index of current owner; valid only while busy=1.
- busy  output  1  high when some oe bit is high.
- turn  output  1  high during turnaround cycles (bus floating).

Behaviour:
- Reset (asynchronous): oe=0, owner=0, busy=0, turn=0, state=IDLE, hold counter=0, round-robin pointer last=N-1, so requester 0 wins first.
- States:
  - IDLE: all oe=0.
  - GRANT: oe[owner]=1, busy=1.
  - TURN: oe=0, turn=1, counts TURNAROUND cycles.
- Arbitration function: pick the first set req bit searching from last+1 upward, wrapping modulo N.
- IDLE → GRANT:
  - Any req high at a rising edge → GRANT at that edge.
  - oe goes high one cycle after req is first sampled (latency 1).
  - No turnaround, because the bus already floats.
  - last := winner; hold counter := 1.
- GRANT, req[owner]=1:
  - Stay in GRANT; hold counter increments, saturating at MAX_HOLD.
- GRANT → TURN:
  - Taken at the edge where req[owner]=0, or where hold counter==MAX_HOLD and any other req bit is set.
  - oe drops to 0 at that edge; the turn counter loads TURNAROUND.
- Hold limit: if hold counter==MAX_HOLD and no other req is pending, the owner keeps the bus indefinitely and the counter saturates.
- TURN:
  - Decrement each cycle; turn stays high for exactly TURNAROUND cycles.
  - On expiry: if any req is set, arbitrate → GRANT at that edge; else → IDLE.
  - A forced-off owner still requesting rejoins arbitration with lowest priority, because last = its index.
- Invariants:
  - popcount(oe) ≤ 1 in every cycle.
  - oe never changes directly from one one-hot value to a different one; at least TURNAROUND all-zero cycles separate any two owners.
  - Same owner re-granted after its own release also passes through TURN.
- req changes during TURN are ignored until TURN expiry; only req at the expiry edge counts.
- Reset asserted mid-GRANT: oe clears immediately (asynchronous), so the bus floats at once.
- Widths: hold counter $clog2(MAX_HOLD+1) bits; turn counter $clog2(TURNAROUND+1) bits; owner index arithmetic wraps modulo N (N need not be a power of 2).

Decomposition:
- Shared package `bus_arb_pkg` holds:
  - state enum (IDLE, GRANT, TURN);
  - default constants N_DEF=4, TURNAROUND_DEF=1, MAX_HOLD_DEF=8;
  - function `rr_pick(req, last)` returning a one-hot winner.
- One natural sub-module: `rr_priority_pick`, purely combinational round-robin selector (req, last → grant one-hot, index, any).
- FSM, counters and registered outputs stay in `tristate_bus_arbiter`.
- Bench instantiates N `tristate_buffer` instances with oe[i] → c and a per-requester constant on a, all tied to one wire y.

Test Plan:
- Reset then req=4'b0001 held → oe=4'b0001 one cycle after first sample, busy=1, y equals requester-0 data; release req → next cycle oe=0, turn=1 for 1 cycle, y===z, then IDLE.
- req=4'b0101 from IDLE (TURNAROUND=1) → owner 0 first; drop req[0] → oe=0 for 1 cycle (y===z), then oe=4'b0100; never oe=4'b0101.
- req=4'b1111 held, MAX_HOLD=8 → each owner gets exactly 8 GRANT cycles then 1 TURN; grant order 0,1,2,3,0.
- req=4'b0010 held alone for 20 cycles → oe=4'b0010 continuously for 20 cycles, no TURN inserted.
- TURNAROUND=3, owner 2 releases while req[3]=1 → exactly 3 all-zero oe cycles, then oe=4'b1000.
- Assert rst mid-GRANT (oe=4'b0100) between edges → oe=0 and y===z before the next clock edge; after release requester 0 has priority.
- Throughout all tests, checker asserts popcount(oe)≤1 every cycle.
